// File: rtl/tank_ctrl.sv
// Per-player tank controller: turns frame-rate direction strobes into clamped grid steps,
// and tracks life with post-hit invulnerability. Frozen outside PLAY and once dead.
module tank_ctrl #(
  parameter int POS_W         = 6,
  parameter int X_MAX         = 39,
  parameter int Y_MAX         = 29,
  parameter int HOLD_FRAMES   = 4,
  parameter int LIFE_MAX      = 5,
  parameter int LIFE_W        = 3,
  parameter int INVULN_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [POS_W-1:0]  i_initial_x,
  input  logic [POS_W-1:0]  i_initial_y,
  input  logic [1:0]        i_initial_direction,
  input  logic [2:0]        i_direction_in,
  input  logic              i_valid_take_direction,
  input  logic              i_blocked,
  input  logic [1:0]        i_game_state,
  input  logic              i_is_hurt,
  output logic [POS_W-1:0]  o_tank_x_pos,
  output logic [POS_W-1:0]  o_tank_y_pos,
  output logic [1:0]        o_direction_out,
  output logic [LIFE_W-1:0] o_tank_life,
  output logic              o_invincible,
  output logic              o_is_dead
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES);
  localparam int INV_W  = $clog2(INVULN_FRAMES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [INV_W-1:0]  INV_LOAD  = INV_W'(INVULN_FRAMES);
  localparam logic [INV_W-1:0]  INV_ONE   = INV_W'(1);
  localparam logic [INV_W-1:0]  INV_ZERO  = {INV_W{1'b0}};
  localparam logic [LIFE_W-1:0] LIFE_FULL = LIFE_W'(LIFE_MAX);
  localparam logic [LIFE_W-1:0] LIFE_ONE  = LIFE_W'(1);
  localparam logic [LIFE_W-1:0] LIFE_ZERO = {LIFE_W{1'b0}};
  localparam logic [POS_W-1:0]  POS_XMAX  = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]  POS_YMAX  = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0]  POS_ZERO  = {POS_W{1'b0}};
  localparam logic [2:0]        DIR_STAND = 3'd4;

  typedef enum logic [1:0] {
    GS_IDLE    = 2'b00,
    GS_PLAY    = 2'b01,
    GS_RESTART = 2'b10,
    GS_PAUSE   = 2'b11
  } game_state_e;

  logic [POS_W-1:0]  r_x, r_y, w_x, w_y;
  logic [1:0]        r_dir, w_dir;
  logic [LIFE_W-1:0] r_life, w_life;
  logic [2:0]        r_dir_last, w_dir_last;
  logic [HOLD_W-1:0] r_hold, w_hold;
  logic [INV_W-1:0]  r_invuln, w_invuln;
  logic              r_invincible, r_dead;
  logic              w_invincible, w_dead;
  game_state_e       w_gs;

  assign w_gs = game_state_e'(i_game_state);

  // Next-state: restart reload, PLAY strobe/hurt processing, otherwise hold everything
  always_comb begin
    w_x        = r_x;
    w_y        = r_y;
    w_dir      = r_dir;
    w_life     = r_life;
    w_dir_last = r_dir_last;
    w_hold     = r_hold;
    w_invuln   = r_invuln;
    case (w_gs)
      GS_RESTART: begin
        w_x        = i_initial_x;
        w_y        = i_initial_y;
        w_dir      = i_initial_direction;
        w_life     = LIFE_FULL;
        w_dir_last = DIR_STAND;
        w_hold     = HOLD_ZERO;
        w_invuln   = INV_ZERO;
      end
      GS_PLAY: begin
        if (!r_dead) begin
          if (i_valid_take_direction) begin
            if (r_invuln != INV_ZERO) begin
              w_invuln = r_invuln - INV_ONE;
            end else begin
              w_invuln = INV_ZERO;
            end
            if (i_direction_in[2]) begin
              w_dir_last = DIR_STAND;
              w_hold     = HOLD_ZERO;
            end else begin
              w_dir = i_direction_in[1:0];
              if (i_direction_in != r_dir_last) begin
                w_dir_last = i_direction_in;
                w_hold     = HOLD_ONE;
              end else if (r_hold != HOLD_LAST) begin
                w_hold = r_hold + HOLD_ONE;
              end else begin
                // Hold period complete: the hold counter restarts even if the step is refused
                w_hold = HOLD_ZERO;
                if (!i_blocked) begin
                  case (i_direction_in[1:0])
                    2'd0:    if (r_y != POS_ZERO) w_y = r_y - POS_ONE; else w_y = r_y;
                    2'd1:    if (r_y != POS_YMAX) w_y = r_y + POS_ONE; else w_y = r_y;
                    2'd2:    if (r_x != POS_ZERO) w_x = r_x - POS_ONE; else w_x = r_x;
                    2'd3:    if (r_x != POS_XMAX) w_x = r_x + POS_ONE; else w_x = r_x;
                    default: w_x = r_x;
                  endcase
                end else begin
                  w_x = r_x;
                end
              end
            end
          end else begin
            w_hold = r_hold;
          end
          // Hurt test looks at the pre-cycle counter; its reload overrides the strobe decrement
          if (i_is_hurt && (r_invuln == INV_ZERO) && (r_life != LIFE_ZERO)) begin
            w_life   = r_life - LIFE_ONE;
            w_invuln = INV_LOAD;
          end else begin
            w_life = r_life;
          end
        end else begin
          w_life = r_life;
        end
      end
      default: w_life = r_life;
    endcase
    w_invincible = (w_invuln != INV_ZERO);
    w_dead       = (w_life == LIFE_ZERO);
  end

  // State and output registers; reset spawns the tank at the supplied position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x          <= i_initial_x;
      r_y          <= i_initial_y;
      r_dir        <= i_initial_direction;
      r_life       <= LIFE_FULL;
      r_dir_last   <= DIR_STAND;
      r_hold       <= HOLD_ZERO;
      r_invuln     <= INV_ZERO;
      r_invincible <= 1'b0;
      r_dead       <= 1'b0;
    end else begin
      r_x          <= w_x;
      r_y          <= w_y;
      r_dir        <= w_dir;
      r_life       <= w_life;
      r_dir_last   <= w_dir_last;
      r_hold       <= w_hold;
      r_invuln     <= w_invuln;
      r_invincible <= w_invincible;
      r_dead       <= w_dead;
    end
  end

  assign o_tank_x_pos    = r_x;
  assign o_tank_y_pos    = r_y;
  assign o_direction_out = r_dir;
  assign o_tank_life     = r_life;
  assign o_invincible    = r_invincible;
  assign o_is_dead       = r_dead;

endmodule

// File: doc/tank_ctrl.md
# tank_ctrl

Parametrised per-player tank controller, the successor to the fixed 6-bit tank block. Integrates per-frame direction requests into grid steps after a configurable hold time, clamps movement to the playfield, honours a game-supplied obstruction flag, and manages life with post-hit invulnerability frames. Sits between the Game FSM (direction strobes, hurt, game state) and the VGA renderer (position, facing, life, blink flag).

## Interface
Parameters:
- POS_W, 6, width of x/y position
- X_MAX, 39, largest legal x (inclusive)
- Y_MAX, 29, largest legal y (inclusive)
- HOLD_FRAMES, 4, consecutive same-direction strobes per grid step (≥2)
- LIFE_MAX, 5, life after reset/restart (≥1)
- LIFE_W, 3, life width (must hold LIFE_MAX)
- INVULN_FRAMES, 8, strobes of invulnerability after a hit (≥1)

Ports (clock and reset are fixed: one clock, asynchronous active-low reset):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- initial_x / initial_y  in  POS_W  spawn position; driver keeps ≤X_MAX / ≤Y_MAX
- initial_direction  in  2  spawn facing
- direction_in  in  3  0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4–7 STAND
- valid_take_direction  in  1  one-cycle frame strobe; direction_in and blocked valid this cycle
- blocked  in  1  step in direction_in would hit an obstacle
- game_state  in  2  00 IDLE, 01 PLAY, 10 RESTART, 11 PAUSE
- is_hurt  in  1  hit this cycle (one-cycle pulse per hit)
- tank_x_pos / tank_y_pos  out  POS_W  registered position
- direction_out  out  2  registered facing
- tank_life  out  LIFE_W  registered life
- invincible  out  1  invuln_cnt != 0
- is_dead  out  1  tank_life == 0

## Operation
- Internal state: dir_last (3b, STAND/0–3), hold_cnt (0..HOLD_FRAMES-1), invuln_cnt (0..INVULN_FRAMES).
- Priority per cycle: RESTART > dead/non-PLAY freeze > hurt and strobe processing.
- game_state==10: synchronous reload of position, direction_out←initial_direction, life←LIFE_MAX, invuln_cnt←0, hold_cnt←0, dir_last←STAND. Holds while asserted.
- game_state 00/11, or is_dead: strobes and is_hurt ignored; all state frozen.
- PLAY strobe, direction_in d ≥4 (STAND): dir_last←STAND, hold_cnt←0, direction_out unchanged.
- PLAY strobe, d in 0–3: direction_out←d immediately.
  - d != dir_last: dir_last←d, hold_cnt←1.
  - d == dir_last, hold_cnt < HOLD_FRAMES-1: hold_cnt+1.
  - d == dir_last, hold_cnt == HOLD_FRAMES-1: hold_cnt←0; step one cell unless blocked=1 or at edge (UP y==0, DOWN y==Y_MAX, LEFT x==0, RIGHT x==X_MAX). Never wraps.
- Hurt in PLAY: if invuln_cnt==0 and life>0: life−1, invuln_cnt←INVULN_FRAMES. While invuln_cnt>0, is_hurt is ignored.
- invuln_cnt decrements by 1 on each PLAY strobe while nonzero, saturating at 0.
- Life never underflows; reaching 0 asserts is_dead and freezes the tank until RESTART.

## Timing
- Reset (rst_n=0, async): tank_x_pos=initial_x, tank_y_pos=initial_y, direction_out=initial_direction, tank_life=LIFE_MAX, invincible=0, is_dead=0, dir_last=STAND, hold_cnt=0, invuln_cnt=0.
- All outputs registered or decoded from registers only; effects visible the cycle after the strobe or hurt edge.
- First step after a direction change occurs on the HOLD_FRAMES-th consecutive strobe with that direction; subsequent steps occur every HOLD_FRAMES strobes.
- Strobe and hurt in the same cycle: both apply. Hurt test uses the pre-cycle invuln_cnt. A hurt load of INVULN_FRAMES wins over the strobe decrement.
- A hit that drops life to 0 in the same cycle as a stepping strobe: the step still applies, and freeze starts the next cycle.
- Leaving PAUSE resumes with hold_cnt and invuln_cnt unchanged.

## Test plan
- Reset with initial (10,10), dir 2 → outputs (10,10), direction_out=2, life=5, invincible=0, is_dead=0.
- PLAY, 8 strobes of RIGHT → x=11 after 4th strobe, x=12 after 8th; direction_out=3 after 1st strobe.
- At x=X_MAX=39, 4 RIGHT strobes → x stays 39, hold_cnt returns to 0. Same at y=0 with UP. With blocked=1 on the 4th strobe → no move.
- is_hurt at cycle t → life 4, invincible=1. Further hurts during the next 7 strobes are ignored. After the 8th strobe invincible=0, and the next hurt gives life 3.
- 5 spaced hits (8 strobes apart) → life 0, is_dead=1. Subsequent strobes and hurts change nothing. game_state=10 → life 5, position = initial.
- PAUSE after 2 UP strobes, 3 strobes during PAUSE, then PLAY with 2 UP strobes → exactly one step on the 2nd post-pause strobe. Hurt in the same cycle as a strobe with invuln_cnt=0 → invuln_cnt=8, not 7.
